// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the core tile sequencer.
// Holds the 34-bit instruction bit map, the idle instruction word and
// the sequencer state encoding.
package core_pkg;

    // Instruction word width and bit positions inside it.
    localparam int INST_W    = 34;
    localparam int ACC       = 33;
    localparam int PM_CEN    = 32;
    localparam int PM_WEN    = 31;
    localparam int PM_A_LSB  = 20;
    localparam int XM_CEN    = 19;
    localparam int XM_WEN    = 18;
    localparam int XM_A_LSB  = 7;
    localparam int OFIFO_RD  = 6;
    localparam int IFIFO_WR  = 5;
    localparam int IFIFO_RD  = 4;
    localparam int L0_RD     = 3;
    localparam int L0_WR     = 2;
    localparam int EXECUTE   = 1;
    localparam int LOAD      = 0;

    // Both SRAM address fields are 11 bits wide.
    localparam int FIELD_A_W = 11;

    // Idle word: both SRAMs deselected (CEN=1) and write-disabled (WEN=1),
    // every other control bit low.
    localparam logic [INST_W-1:0] INST_IDLE =
        (INST_W'(1) << PM_CEN) | (INST_W'(1) << PM_WEN) |
        (INST_W'(1) << XM_CEN) | (INST_W'(1) << XM_WEN);

    // Tile phases in execution order.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WLD   = 3'd1,
        KLD   = 3'd2,
        XLD   = 3'd3,
        EXEC  = 3'd4,
        DRAIN = 3'd5,
        DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/core_seq_addr_gen.sv
// core_seq_addr_gen: base + offset address generator, wrapping modulo
// 2^ADDR_W. The output looks through a load so the loaded base can be
// issued in the same cycle it is captured; a simultaneous increment makes
// the following address base+1.
module core_seq_addr_gen #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] base_in,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] off_q;

    // Base/offset registers: load restarts at base, inc advances offset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q <= '0;
            off_q  <= '0;
        end else if (load) begin
            base_q <= base_in;
            off_q  <= inc ? ADDR_W'(1) : '0;
        end else if (inc) begin
            off_q  <= off_q + ADDR_W'(1);
        end
    end

    // Current address; the sum truncates to ADDR_W bits, giving the wrap.
    assign addr = load ? base_in : (base_q + off_q);

endmodule

// File: rtl/core_seq.sv
// core_seq: tile instruction sequencer for core.
// One start runs weight fetch into L0, kernel load, activation fetch,
// execute and OFIFO drain into PSUM SRAM, then pulses done.
// Every output is a flop loaded from next-state decode, so output words
// line up with the state they belong to and never glitch.
// Optional feature: define CORE_SEQ_PERF_EN to add the cycle_cnt port,
// a count of busy cycles in the most recent tile.
//
// OFIFO handshake: ofifo_valid is sampled at the clock edge that begins a
// cycle. When that edge lands in DRAIN with vectors still owed, the word
// for that cycle carries ofifo_rd=1 together with the PSUM write of the
// popped vector, so one sampled valid produces exactly one read and one
// write. ofifo_valid has no effect in any other state.
module core_seq
    import core_pkg::*;
#(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int row     = 8,
    parameter int ADDR_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_x,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] x_base,
    input  logic [ADDR_W-1:0] p_base,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              xw_mode,
    output logic              pmem_mode,
    output logic              busy,
    output logic              done,
    output state_t            state_dbg
`ifdef CORE_SEQ_PERF_EN
    ,
    output logic [31:0]       cycle_cnt
`endif
);

    // Parameter sanity guard: address fields are fixed at 11 bits.
    if (ADDR_W != FIELD_A_W || bw < 1 || psum_bw < 1 || col < 1 || row < 1) begin : g_cfg_invalid
    end

    // k counts cycles within a phase (writes done, while in DRAIN);
    // one extra bit covers num_x+1 phase lengths.
    localparam int K_W = ADDR_W + 1;
    localparam logic [K_W-1:0] K_COL      = K_W'(col);
    localparam logic [K_W-1:0] K_KLD_LAST = K_W'(col + row - 1);

    state_t            state_q, state_nxt;
    logic [K_W-1:0]    k_q, k_nxt, k_base, nx_k;
    logic [ADDR_W-1:0] num_x_q, x_base_q;
    logic              start_acc, entering, wr_en;
    logic [INST_W-1:0] inst_nxt;
    logic              xw_nxt, done_nxt;
    logic              x_load, x_inc, p_inc;
    logic [ADDR_W-1:0] x_load_val, x_addr, p_addr;

    assign nx_k      = {1'b0, num_x_q};
    assign start_acc = (state_q == IDLE) && start;
    assign pmem_mode = 1'b0;
    assign state_dbg = state_q;

    // Activation/weight SRAM address: weights from start, activations
    // restart at x_base on entry to XLD.
    assign x_load     = start_acc || ((state_nxt == XLD) && (state_q != XLD));
    assign x_load_val = start_acc ? w_base : x_base_q;

    core_seq_addr_gen #(.ADDR_W(ADDR_W)) u_xaddr (
        .clk     (clk),
        .reset   (reset),
        .load    (x_load),
        .inc     (x_inc),
        .base_in (x_load_val),
        .addr    (x_addr)
    );

    // PSUM SRAM address: set up at start, advanced once per drained vector.
    core_seq_addr_gen #(.ADDR_W(ADDR_W)) u_paddr (
        .clk     (clk),
        .reset   (reset),
        .load    (start_acc),
        .inc     (p_inc),
        .base_in (p_base),
        .addr    (p_addr)
    );

    // Next-state decode: each phase leaves on its last counted cycle.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (start) state_nxt = WLD;
            WLD:     if (k_q == K_COL) state_nxt = KLD;
            KLD:     if (k_q == K_KLD_LAST) state_nxt = (num_x_q == '0) ? DONE : XLD;
            XLD:     if (k_q == nx_k) state_nxt = EXEC;
            EXEC:    if (k_q == nx_k - K_W'(1)) state_nxt = DRAIN;
            DRAIN:   if (k_q == nx_k) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Phase counter: restarts on phase entry; in DRAIN it counts writes.
    always_comb begin
        entering = (state_nxt != state_q);
        k_base   = entering ? '0 : k_q;
        wr_en    = (state_nxt == DRAIN) && ofifo_valid && (k_base < nx_k);
        if (state_nxt == IDLE)
            k_nxt = '0;
        else if (state_nxt == DRAIN)
            k_nxt = k_base + {{(K_W-1){1'b0}}, wr_en};
        else if (entering)
            k_nxt = '0;
        else
            k_nxt = k_q + K_W'(1);
    end

    // Output decode for the cycle being entered.
    always_comb begin
        inst_nxt = INST_IDLE;
        xw_nxt   = 1'b0;
        done_nxt = 1'b0;
        x_inc    = 1'b0;
        p_inc    = 1'b0;
        case (state_nxt)
            WLD, XLD: begin
                xw_nxt = (state_nxt == WLD);
                if (k_nxt < ((state_nxt == WLD) ? K_COL : nx_k)) begin
                    inst_nxt[XM_CEN]                = 1'b0;
                    inst_nxt[XM_A_LSB +: ADDR_W]    = x_addr;
                    x_inc                           = 1'b1;
                end
                // SRAM data arrives one cycle after its read.
                if (k_nxt != '0) inst_nxt[L0_WR] = 1'b1;
            end
            KLD: begin
                if (k_nxt < K_COL) begin
                    inst_nxt[L0_RD] = 1'b1;
                    inst_nxt[LOAD]  = 1'b1;
                end
            end
            EXEC: begin
                inst_nxt[L0_RD]   = 1'b1;
                inst_nxt[EXECUTE] = 1'b1;
            end
            DRAIN: begin
                if (wr_en) begin
                    inst_nxt[OFIFO_RD]           = 1'b1;
                    inst_nxt[PM_CEN]             = 1'b0;
                    inst_nxt[PM_WEN]             = 1'b0;
                    inst_nxt[PM_A_LSB +: ADDR_W] = p_addr;
                    p_inc                        = 1'b1;
                end
            end
            DONE:    done_nxt = 1'b1;
            default: ;
        endcase
        // Accumulate and IFIFO controls are not used by this sequencer.
        inst_nxt[ACC]      = 1'b0;
        inst_nxt[IFIFO_WR] = 1'b0;
        inst_nxt[IFIFO_RD] = 1'b0;
    end

    // State, captured tile parameters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            k_q      <= '0;
            num_x_q  <= '0;
            x_base_q <= '0;
            inst     <= INST_IDLE;
            xw_mode  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q <= state_nxt;
            k_q     <= k_nxt;
            if (start_acc) begin
                num_x_q  <= num_x;
                x_base_q <= x_base;
            end
            inst    <= inst_nxt;
            xw_mode <= xw_nxt;
            busy    <= (state_nxt != IDLE);
            done    <= done_nxt;
        end
    end

`ifdef CORE_SEQ_PERF_EN
    // Busy-cycle counter; counts the cycle being entered, so while done
    // is high it already holds the full tile length, then holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cycle_cnt <= '0;
        else if (start_acc)
            cycle_cnt <= 32'd1;
        else if (state_nxt != IDLE)
            cycle_cnt <= cycle_cnt + 32'd1;
    end
`endif

endmodule

// File: doc/core_seq.md
# core_seq

Tile instruction sequencer driving the 34-bit `inst` bus and mode selects of `core`; sits directly upstream of `core`, replacing testbench-generated instruction streams. On `start` it runs one full tile: weight fetch into L0, kernel load, activation fetch, execute, then OFIFO drain into PSUM SRAM, and pulses `done`. All outputs are registered; `core` sees clean, glitch-free control every cycle.

## Interface
- `bw`, 4, activation/weight bit width
- `psum_bw`, 16, partial-sum width
- `col`, 8, array columns (weight vectors per tile)
- `row`, 8, array rows
- `ADDR_W`, 11, SRAM address width
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; all state to IDLE
- `start`  in  1  begin tile; sampled only in IDLE
- `num_x`  in  ADDR_W  activation vectors per tile; captured at start
- `w_base`, `x_base`, `p_base`  in  ADDR_W each  weight/activation/psum base addresses; captured at start
- `ofifo_valid`  in  1  OFIFO has a full output vector
- `inst`  out  34  instruction to `core`
- `xw_mode`  out  1  0 = activation SRAM, 1 = weight SRAM
- `pmem_mode`  out  1  held 0 (PSUM written from OFIFO)
- `busy`  out  1  high in every non-IDLE state
- `done`  out  1  one-cycle pulse at tile end
- `cycle_cnt`  out  32  present only with `CORE_SEQ_PERF_EN`

## Operation
- inst fields: [33] acc (held 0), [32] pmem CEN, [31] pmem WEN, [30:20] pmem A, [19] xmem CEN, [18] xmem WEN, [17:7] xmem A, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd (5:4 held 0), [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
- Idle word: CEN/WEN bits = 1, everything else 0. Emitted in IDLE, DONE and after reset.
- States and counter k (reset to 0 on each entry):
- IDLE: `start` -> WLD; captures inputs.
- WLD: col+1 cycles, xw_mode=1. Cycles k<col: xmem CEN=0, WEN=1, A=w_base+k. Cycles k>=1: l0_wr=1 (SRAM read latency 1). -> KLD.
- KLD: col+row cycles; l0_rd=1 and load=1 for k<col, then idle word. -> XLD, or DONE if num_x==0.
- XLD: num_x+1 cycles, xw_mode=0, same pattern as WLD with x_base and num_x. -> EXEC.
- EXEC: num_x cycles, l0_rd=1, execute=1. -> DRAIN.
- DRAIN: count n = vectors written. Each cycle with `ofifo_valid` and n<num_x: ofifo_rd=1, pmem CEN=0, WEN=0, A=p_base+n in the same word; n increments. n==num_x -> DONE.
- DONE: one cycle, `done`=1 -> IDLE.
- Address arithmetic modulo 2^ADDR_W (wrap, no error).
- `start` while busy is ignored; captured values are not disturbed.
- `ofifo_valid` outside DRAIN is ignored.

## Timing
- Reset: IDLE, inst = idle word, xw_mode=0, pmem_mode=0, busy=0, done=0, cycle_cnt=0.
- `start` at edge t -> busy=1 and first WLD word at t+1.
- Total latency (num_x=N>0, ofifo_valid continuously high in DRAIN): (col+1)+(col+row)+(N+1)+N+N+1 cycles from first WLD word to `done`.
- Reset mid-tile: outputs return to reset values asynchronously; no partial pmem write completes after reset.
- DRAIN stalls indefinitely while ofifo_valid=0; no timeout.

## Configuration
- `CORE_SEQ_PERF_EN` defined: `cycle_cnt` port exists; clears on `start`, increments every busy cycle, holds after `done` until next start.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Package `core_pkg`: inst bit-position constants, idle-word constant, state enum (IDLE, WLD, KLD, XLD, EXEC, DRAIN, DONE).
- One sub-module: `core_seq_addr_gen` (base + offset, modulo-wrapped address register with load/increment).

## Test plan
- Reset during EXEC -> next cycle inst=idle word, busy=0, done never pulses.
- col=row=8, num_x=4, w_base=0x10: WLD reads 0x10..0x17, l0_wr high on 8 cycles each one cycle after its read.
- num_x=0 -> sequence WLD, KLD, DONE; no xmem activation read, no pmem write.
- DRAIN with ofifo_valid toggling 1,0,1,1,0,1 and num_x=4 -> exactly 4 pmem writes to p_base..p_base+3, only on valid cycles.
- p_base=0x7FE, num_x=4 -> pmem addresses 0x7FE, 0x7FF, 0x000, 0x001.
- `start` pulsed mid-tile -> ignored; with `CORE_SEQ_PERF_EN`, cycle_cnt at done equals latency formula (num_x=4: 9+16+5+4+4+1=39).
